// File: rtl/brent_kung_mod_sub_pipe.sv
// -----------------------------------------------------------------------------
// brent_kung_mod_sub_pipe
//
// Pipelined modular subtractor: S = (A - B) mod Q.
//   Stage 1: {c, D} = A + ~B + 1 through a Brent-Kung prefix carry network.
//            A carry-out of 0 means A < B, so the difference wrapped (borrow).
//   Stage 2: when a borrow occurred, add Q back with a second Brent-Kung adder
//            (sum truncated to WIDTH bits); otherwise pass D through.
// Latency is 2 cycles, throughput is 1 result per cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holding valid may not see it dropped; the output side keeps
// valid_o, S_o and borrow_o unchanged while valid_o=1 and ready_i=0. ready_o is
// combinational from ready_i (no skid buffer), so a full pipe whose head is
// being drained can still accept a new operand in the same cycle.
//
// Ports:
//   clk_i     in   1      clock, all state on rising edge
//   rst_i     in   1      synchronous reset, active-high
//   valid_i   in   1      input operands valid
//   ready_o   out  1      block can accept operands this cycle
//   A_i       in   WIDTH  minuend, expected in [0, Q-1]
//   B_i       in   WIDTH  subtrahend, expected in [0, Q-1]
//   valid_o   out  1      result valid
//   ready_i   in   1      downstream accepts result this cycle
//   S_o       out  WIDTH  result (A_i - B_i) mod Q
//   borrow_o  out  1      1 when A_i < B_i (Q was added back)
// -----------------------------------------------------------------------------
module brent_kung_mod_sub_pipe #(
    parameter int WIDTH = 16,
    parameter int Q     = 12289
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] S_o,
    output logic             borrow_o
);

    localparam int              LOG = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

    // Brent-Kung adder: returns {carry_out, sum}. The carry-in is folded into
    // the bit-0 generate so every prefix group already includes it, which makes
    // gg[i] the carry out of bit i.
    function automatic logic [WIDTH:0] bk_add(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             cin
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] gg;
        logic [WIDTH-1:0] pp;
        logic [WIDTH:0]   c;
        g     = x & y;
        p     = x ^ y;
        gg    = g;
        gg[0] = g[0] | (p[0] & cin);
        pp    = p;
        // Up-sweep: node i combines with i-d when i+1 is a multiple of 2d.
        for (int l = 0; l < LOG; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end
        // Down-sweep: fill in the remaining prefixes from the completed ones.
        // Only group generate is needed here; the upper node's propagate is
        // already the correct block propagate from the up-sweep.
        for (int l = LOG - 2; l >= 0; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((i >= ((3 << l) - 1)) && (((i + 1 - (1 << l)) % (2 << l)) == 0)) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                end
            end
        end
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            c[i + 1] = gg[i];
        end
        return {c[WIDTH], p ^ c[WIDTH-1:0]};
    endfunction

    // Pipeline registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_diff;
    logic             s1_borrow;
    logic             s2_valid;

    // Flow control
    logic adv1;
    logic adv2;

    // Datapath
    logic [WIDTH:0]   sub_full;
    logic [WIDTH:0]   corr_full;
    logic [WIDTH-1:0] res;
    logic             unused_corr_cout;

    assign adv2    = !s2_valid || ready_i;
    assign adv1    = !s1_valid || adv2;
    assign ready_o = adv1;
    assign valid_o = s2_valid;

    assign sub_full  = bk_add(A_i, ~B_i, 1'b1);
    assign corr_full = bk_add(s1_diff, Q_W, 1'b0);
    // The carry out of the +Q correction is discarded: the result is mod 2**WIDTH.
    assign unused_corr_cout = corr_full[WIDTH];
    assign res = s1_borrow ? corr_full[WIDTH-1:0] : s1_diff;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid  <= 1'b0;
            s1_diff   <= '0;
            s1_borrow <= 1'b0;
            s2_valid  <= 1'b0;
            S_o       <= '0;
            borrow_o  <= 1'b0;
        end else begin
            // Data regs may load when valid_i=0; only the valid bits gate results.
            if (adv1) begin
                s1_valid  <= valid_i;
                s1_diff   <= sub_full[WIDTH-1:0];
                s1_borrow <= ~sub_full[WIDTH];
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                S_o      <= res;
                borrow_o <= s1_borrow;
            end
        end
    end

endmodule

// File: tb/tb_brent_kung_mod_sub_pipe.sv
// -----------------------------------------------------------------------------
// tb_brent_kung_mod_sub_pipe
//
// Directed and randomized checks of the pipelined modular subtractor with
// WIDTH=16, Q=12289. Inputs change on the falling edge; outputs are sampled on
// the falling edge (plus #1 where ready_o must settle after ready_i changes).
// -----------------------------------------------------------------------------
module tb_brent_kung_mod_sub_pipe;

    localparam int WIDTH = 16;
    localparam int Q     = 12289;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] B_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] S_o;
    logic             borrow_o;

    int checks   = 0;
    int failures = 0;

    // {borrow, result} of accepted operands, oldest first
    logic [WIDTH:0] exp_q[$];

    brent_kung_mod_sub_pipe #(.WIDTH(WIDTH), .Q(Q)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .A_i      (A_i),
        .B_i      (B_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .S_o      (S_o),
        .borrow_o (borrow_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    // Starts at a falling edge with an empty pipe; sends one operand pair with
    // ready_i=1 and reports whether valid_o rose exactly 2 cycles after accept.
    task automatic run_single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              output logic lat_ok, output logic [WIDTH-1:0] s,
                              output logic bo);
        valid_i = 1'b1;
        A_i     = a;
        B_i     = b;
        ready_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        lat_ok  = (valid_o === 1'b0);
        @(negedge clk);
        lat_ok  = lat_ok && (valid_o === 1'b1);
        s       = S_o;
        bo      = borrow_o;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_i   = 1'b1;
        valid_i = 1'b1;
        A_i     = 16'd7;
        B_i     = 16'd3;
        ready_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || S_o !== 16'd0 || borrow_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b S=%h borrow=%b, expected valid=0 S=0000 borrow=0",
                     valid_o, S_o, borrow_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_early: got valid=%b at accept+1, expected 0", valid_o);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || S_o !== 16'd4 || borrow_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_result: got valid=%b S=%h borrow=%b, expected valid=1 S=0004 borrow=0",
                     valid_o, S_o, borrow_o);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_dup: got valid=%b after transfer, expected 0", valid_o);
        end
    endtask

    task automatic test_no_borrow;
        logic             lat_ok;
        logic [WIDTH-1:0] s;
        logic             bo;
        run_single(16'h1000, 16'h0234, lat_ok, s, bo);
        checks++;
        if (!lat_ok) begin
            failures++;
            $display("FAIL no_borrow_latency: valid_o not at exactly accept+2, expected 2-cycle latency");
        end
        checks++;
        if (s !== 16'h0DCC || bo !== 1'b0) begin
            failures++;
            $display("FAIL no_borrow_value: got S=%h borrow=%b, expected S=0dcc borrow=0", s, bo);
        end
    endtask

    task automatic test_borrow;
        logic [WIDTH-1:0] va [2];
        logic [WIDTH-1:0] vb [2];
        logic [WIDTH-1:0] es [2];
        logic             lat_ok;
        logic [WIDTH-1:0] s;
        logic             bo;
        va[0] = 16'h0005; vb[0] = 16'h0007; es[0] = 16'h2FFF;
        va[1] = 16'd0;    vb[1] = 16'd12288; es[1] = 16'd1;
        for (int k = 0; k < 2; k++) begin
            run_single(va[k], vb[k], lat_ok, s, bo);
            checks++;
            if (!lat_ok || s !== es[k] || bo !== 1'b1) begin
                failures++;
                $display("FAIL borrow_%0d: got S=%h borrow=%b lat_ok=%b, expected S=%h borrow=1 lat_ok=1",
                         k, s, bo, lat_ok, es[k]);
            end
        end
    endtask

    task automatic test_equal_edge;
        logic [WIDTH-1:0] va [2];
        logic [WIDTH-1:0] vb [2];
        logic [WIDTH-1:0] es [2];
        logic             lat_ok;
        logic [WIDTH-1:0] s;
        logic             bo;
        va[0] = 16'h1234;  vb[0] = 16'h1234; es[0] = 16'd0;
        va[1] = 16'd12288; vb[1] = 16'd0;    es[1] = 16'd12288;
        for (int k = 0; k < 2; k++) begin
            run_single(va[k], vb[k], lat_ok, s, bo);
            checks++;
            if (!lat_ok || s !== es[k] || bo !== 1'b0) begin
                failures++;
                $display("FAIL equal_edge_%0d: got S=%h borrow=%b lat_ok=%b, expected S=%h borrow=0 lat_ok=1",
                         k, s, bo, lat_ok, es[k]);
            end
        end
    endtask

    // Out-of-range operands: plain truncated arithmetic, no clamping.
    task automatic test_out_of_range;
        logic [WIDTH-1:0] va [3];
        logic [WIDTH-1:0] vb [3];
        logic [WIDTH-1:0] es [3];
        logic             eb [3];
        logic             lat_ok;
        logic [WIDTH-1:0] s;
        logic             bo;
        va[0] = 16'hFFFF; vb[0] = 16'h0000; es[0] = 16'hFFFF; eb[0] = 1'b0;
        va[1] = 16'h0000; vb[1] = 16'hFFFF; es[1] = 16'h3002; eb[1] = 1'b1;
        va[2] = 16'h0000; vb[2] = 16'h0001; es[2] = 16'h3000; eb[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_single(va[k], vb[k], lat_ok, s, bo);
            checks++;
            if (!lat_ok || s !== es[k] || bo !== eb[k]) begin
                failures++;
                $display("FAIL out_of_range_%0d: got S=%h borrow=%b lat_ok=%b, expected S=%h borrow=%b lat_ok=1",
                         k, s, bo, lat_ok, es[k], eb[k]);
            end
        end
    endtask

    // Four ops streamed; ready_i low during cycles 3..5 with both stages full.
    task automatic test_backpressure;
        logic [WIDTH-1:0] oa [4];
        logic [WIDTH-1:0] ob [4];
        logic [WIDTH-1:0] os [4];
        logic             obr [4];
        logic             er [10];
        int               idx;
        int               got;
        oa[0] = 16'd100;   ob[0] = 16'd50;    os[0] = 16'd50;    obr[0] = 1'b0;
        oa[1] = 16'd3;     ob[1] = 16'd9;     os[1] = 16'd12283; obr[1] = 1'b1;
        oa[2] = 16'd12288; ob[2] = 16'd1;     os[2] = 16'd12287; obr[2] = 1'b0;
        oa[3] = 16'd1;     ob[3] = 16'd12288; os[3] = 16'd2;     obr[3] = 1'b1;
        er[0] = 1'b1; er[1] = 1'b1; er[2] = 1'b1; er[3] = 1'b0; er[4] = 1'b0;
        er[5] = 1'b0; er[6] = 1'b1; er[7] = 1'b1; er[8] = 1'b1; er[9] = 1'b1;
        idx = 0;
        got = 0;
        for (int c = 0; c < 14; c++) begin
            valid_i = (idx < 4);
            A_i     = oa[(idx < 4) ? idx : 0];
            B_i     = ob[(idx < 4) ? idx : 0];
            ready_i = !(c >= 3 && c <= 5);
            #1;
            if (c < 10) begin
                checks++;
                if (ready_o !== er[c]) begin
                    failures++;
                    $display("FAIL bp_ready_c%0d: got ready_o=%b, expected %b", c, ready_o, er[c]);
                end
            end
            if (c >= 3 && c <= 5) begin
                checks++;
                if (valid_o !== 1'b1 || S_o !== os[1] || borrow_o !== obr[1]) begin
                    failures++;
                    $display("FAIL bp_hold_c%0d: got valid=%b S=%0d borrow=%b, expected valid=1 S=%0d borrow=%b",
                             c, valid_o, S_o, borrow_o, os[1], obr[1]);
                end
            end
            if (valid_o && ready_i) begin
                checks++;
                if (got >= 4) begin
                    failures++;
                    $display("FAIL bp_extra: got extra result S=%0d, expected only 4 results", S_o);
                end else if (S_o !== os[got] || borrow_o !== obr[got]) begin
                    failures++;
                    $display("FAIL bp_order_%0d: got S=%0d borrow=%b, expected S=%0d borrow=%b",
                             got, S_o, borrow_o, os[got], obr[got]);
                end
                got++;
            end
            if (valid_i && ready_o) idx++;
            @(negedge clk);
        end
        valid_i = 1'b0;
        checks++;
        if (got != 4 || idx != 4) begin
            failures++;
            $display("FAIL bp_count: got delivered=%0d accepted=%0d, expected 4 and 4", got, idx);
        end
    endtask

    // Fill both stages, reset, and confirm nothing in flight ever emerges.
    task automatic test_flush_reset;
        int leaked;
        ready_i = 1'b0;
        valid_i = 1'b1;
        A_i     = 16'd10;
        B_i     = 16'd4;
        @(negedge clk);
        A_i = 16'd20;
        B_i = 16'd1;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || S_o !== 16'd6 || borrow_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_prefill: got valid=%b S=%0d borrow=%b, expected valid=1 S=6 borrow=0",
                     valid_o, S_o, borrow_o);
        end
        rst_i   = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        rst_i   = 1'b0;
        ready_i = 1'b1;
        checks++;
        if (valid_o !== 1'b0 || S_o !== 16'd0 || borrow_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_outputs: got valid=%b S=%h borrow=%b, expected valid=0 S=0000 borrow=0",
                     valid_o, S_o, borrow_o);
        end
        leaked = 0;
        repeat (4) begin
            @(negedge clk);
            if (valid_o !== 1'b0) leaked++;
        end
        checks++;
        if (leaked != 0) begin
            failures++;
            $display("FAIL flush_leak: got %0d cycles with valid_o=1 after reset, expected 0", leaked);
        end
    endtask

    task automatic test_random;
        int               sent;
        int               cycles;
        bit               pend;
        bit               did_rst;
        bit               prev_stall;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] prev_s;
        logic             prev_b;
        logic [WIDTH:0]   e;
        int               r;
        sent       = 0;
        cycles     = 0;
        pend       = 1'b0;
        did_rst    = 1'b0;
        prev_stall = 1'b0;
        a          = '0;
        b          = '0;
        prev_s     = '0;
        prev_b     = 1'b0;
        exp_q.delete();
        while ((sent < 1000 || exp_q.size() != 0) && cycles < 20000) begin
            cycles++;
            if (!did_rst && sent == 500) begin
                rst_i   = 1'b1;
                valid_i = 1'b0;
                ready_i = 1'($urandom_range(0, 1));
                @(negedge clk);
                rst_i = 1'b0;
                exp_q.delete();
                did_rst    = 1'b1;
                pend       = 1'b0;
                prev_stall = 1'b0;
                checks++;
                if (valid_o !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_flush: got valid_o=%b after reset pulse, expected 0", valid_o);
                end
                continue;
            end
            if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
                a    = 16'($urandom_range(0, Q - 1));
                b    = 16'($urandom_range(0, Q - 1));
                pend = 1'b1;
            end
            valid_i = pend;
            A_i     = a;
            B_i     = b;
            ready_i = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                checks++;
                if (valid_o !== 1'b1 || S_o !== prev_s || borrow_o !== prev_b) begin
                    failures++;
                    $display("FAIL rand_hold: got valid=%b S=%0d borrow=%b, expected valid=1 S=%0d borrow=%b",
                             valid_o, S_o, borrow_o, prev_s, prev_b);
                end
            end
            if (valid_o && ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_unexpected: got S=%0d with nothing outstanding, expected no result", S_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({borrow_o, S_o} !== e) begin
                        failures++;
                        $display("FAIL rand_result: got S=%0d borrow=%b, expected S=%0d borrow=%b",
                                 S_o, borrow_o, e[WIDTH-1:0], e[WIDTH]);
                    end
                end
            end
            if (valid_i && ready_o) begin
                r = (int'(a) - int'(b) + Q) % Q;
                exp_q.push_back({(a < b), 16'(r)});
                sent++;
                pend = 1'b0;
            end
            prev_stall = valid_o && !ready_i;
            prev_s     = S_o;
            prev_b     = borrow_o;
            @(negedge clk);
        end
        valid_i = 1'b0;
        checks++;
        if (sent < 1000 || exp_q.size() != 0 || !did_rst) begin
            failures++;
            $display("FAIL rand_complete: got sent=%0d outstanding=%0d reset_done=%b, expected 1000, 0, 1",
                     sent, exp_q.size(), did_rst);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        A_i     = '0;
        B_i     = '0;
        test_reset();
        test_no_borrow();
        test_borrow();
        test_equal_edge();
        test_out_of_range();
        test_backpressure();
        test_flush_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
